// File: rtl/dq0_to_dq.sv
//==============================================================================
// Module      : dq0_to_dq
// Description : Rebuilds sign-magnitude DQ from the 11-bit ADPCM float word DQ0
//               with a bit-serial shifter (one shift per clock).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dq0_to_dq #(
    parameter int EXPW  = 4,
    parameter int MANTW = 6,
    parameter int DQW   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scan_in0,
    input  logic                      scan_in1,
    input  logic                      scan_in2,
    input  logic                      scan_in3,
    input  logic                      scan_in4,
    input  logic                      scan_enable,
    input  logic                      test_mode,
    output logic                      scan_out0,
    output logic                      scan_out1,
    output logic                      scan_out2,
    output logic                      scan_out3,
    output logic                      scan_out4,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXPW+MANTW:0]       DQ0,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DQW-1:0]            DQ
);

    // Accumulator holds the largest mantissa shifted by the largest exponent.
    localparam int ACCW = MANTW + (1 << EXPW) - 1;
    localparam int MAGW = DQW - 1;
    localparam int SHW  = ACCW - MANTW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [EXPW-1:0] c_cnt_one  = EXPW'(1);
    localparam logic [EXPW-1:0] c_cnt_zero = '0;

    logic [1:0]       r_state;
    logic [ACCW-1:0]  r_acc;
    logic [EXPW-1:0]  r_cnt;
    logic             r_sign;
    logic [DQW-1:0]   r_dq;
    logic             r_out_valid;
    logic [MAGW-1:0]  w_mag;
    logic             w_unused_scan;

    // The fixed right shift by MANTW is just a slice of the accumulator.
    generate
        if (SHW >= MAGW) begin : g_mag_slice
            assign w_mag = r_acc[MANTW +: MAGW];
        end else begin : g_mag_pad
            assign w_mag = {{(MAGW-SHW){1'b0}}, r_acc[ACCW-1:MANTW]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_dq        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc   <= {{(ACCW-MANTW){1'b0}}, DQ0[MANTW-1:0]};
                        r_cnt   <= DQ0[MANTW +: EXPW];
                        r_sign  <= DQ0[MANTW+EXPW];
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != c_cnt_zero) begin
                        r_acc <= r_acc << 1;
                        r_cnt <= r_cnt - c_cnt_one;
                    end else begin
                        r_dq        <= {r_sign, w_mag};
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // No bypass: a new word is taken only after returning to IDLE.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign DQ        = r_dq;

    // Scan chains are stitched in by DFT insertion.
    assign w_unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                             scan_enable, test_mode};
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_dq0_to_dq.sv
//==============================================================================
// Module      : tb_dq0_to_dq
// Description : Scoreboard bench for dq0_to_dq: directed vectors and round trip.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dq0_to_dq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [10:0] DQ0 = '0;
    logic        in_ready, out_valid;
    logic [15:0] DQ;
    logic        so0, so1, so2, so3, so4;

    typedef struct {
        logic [15:0] dq;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        prev_v = 1'b0;
    logic [15:0] prev_dq = '0;

    dq0_to_dq dut (
        .clk(clk), .reset(reset),
        .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
        .scan_enable(1'b0), .test_mode(1'b0),
        .scan_out0(so0), .scan_out1(so1), .scan_out2(so2), .scan_out3(so3), .scan_out4(so4),
        .in_valid(in_valid), .in_ready(in_ready), .DQ0(DQ0),
        .out_valid(out_valid), .out_ready(out_ready), .DQ(DQ)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // Monitor: compares each presented word against the scoreboard head.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && !prev_v) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                chk("dq_value", {16'h0, DQ}, {16'h0, exp_q[0].dq});
                chk("latency_cycle", cyc, exp_q[0].due);
            end
        end
        if (out_valid === 1'b1 && prev_v)
            chk("dq_stable", {16'h0, DQ}, {16'h0, prev_dq});
        if (out_valid === 1'b1)
            chk("in_ready_low_in_done", {31'h0, in_ready}, 32'd0);
        if (out_valid === 1'b1 && out_ready && exp_q.size() != 0)
            void'(exp_q.pop_front());
        prev_v  = (out_valid === 1'b1);
        prev_dq = DQ;
    end

    task automatic send(input logic [10:0] w, input logic [15:0] e);
        int n;
        exp_t x;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk("send_timeout", 32'd1, 32'd0);
            return;
        end
        in_valid = 1'b1;
        DQ0      = w;
        @(posedge clk);
        #1;
        x.dq  = e;
        x.due = cyc + int'(w[9:6]) + 1;
        exp_q.push_back(x);
        in_valid = 1'b0;
    endtask

    function automatic logic [10:0] pack(input logic s, input int mag);
        int e;
        int m;
        e = 0;
        for (int b = 0; b < 15; b++) if (mag[b]) e = b + 1;
        m = (mag == 0) ? 32 : (((mag << 6) >> e) & 63);
        return {s, 4'(e), 6'(m)};
    endfunction

    function automatic logic [15:0] expect_rt(input logic s, input int mag);
        int e;
        int r;
        e = 0;
        for (int b = 0; b < 15; b++) if (mag[b]) e = b + 1;
        r = (e > 6) ? (mag & ~((1 << (e - 6)) - 1)) : mag;
        return {s, 15'(r)};
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int m;
        int n;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_in_ready", {31'h0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'h0, out_valid}, 32'd0);
        chk("reset_dq", {16'h0, DQ}, 32'h0);

        // Directed vectors
        send(11'h020, 16'h0000);
        send(11'h0E8, 16'h0005);
        send(11'h261, 16'h0108);
        send(11'h7FF, 16'hFE00);
        send(11'h420, 16'h8000);
        drain();

        // Backpressure in DONE with a toggling in_valid
        out_ready = 1'b0;
        send(11'h0E8, 16'h0005);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", {31'h0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            DQ0      = 11'h7FF;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", {31'h0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'h0, out_valid}, 32'd0);
        chk("bp_dq_held", {16'h0, DQ}, 32'h0005);
        drain();

        // Reset three cycles into an EXP=12 shift
        send({1'b0, 4'd12, 6'd40}, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        chk("midreset_in_ready", {31'h0, in_ready}, 32'd1);
        chk("midreset_out_valid", {31'h0, out_valid}, 32'd0);
        chk("midreset_dq", {16'h0, DQ}, 32'h0);
        repeat (20) @(posedge clk);

        // Round trip through the reference packer, back-to-back
        m = 0;
        while (m < 32768) begin
            send(pack(1'b0, m), expect_rt(1'b0, m));
            send(pack(1'b1, m), expect_rt(1'b1, m));
            m += (m < 64) ? 1 : 127;
        end
        send(pack(1'b0, 32767), expect_rt(1'b0, 32767));
        send(pack(1'b1, 32767), expect_rt(1'b1, 32767));
        drain();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
